// File: rtl/xdma_core_pkg.sv
// Shared types and AXI constants for the xdma_core PCIe DMA stand-in.
package xdma_core_pkg;

  typedef enum logic [3:0] {
    LINK_WAIT,
    IDLE,
    MM_AW,
    MM_W,
    MM_B,
    MM_AR,
    MM_R,
    L_AW_W,
    L_B,
    L_AR,
    L_R
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] CACHE_DEF   = 4'b0011;

  // AXI size encoding for a full-width beat of dw bits
  function automatic logic [2:0] axi_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/xdma_core_if.sv
// Host command/data port and AXI4 / AXI4-Lite master bundles for xdma_core.

// Host side: master = host model, slave = xdma_core.
interface xdma_core_host_if #(parameter int DW = 256);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic          cmd_bar;
  logic [63:0]   cmd_addr;
  logic [7:0]    cmd_len;
  logic          hw_valid;
  logic          hw_ready;
  logic [DW-1:0] hw_data;
  logic [DW/8-1:0] hw_strb;
  logic          hr_valid;
  logic          hr_ready;
  logic [DW-1:0] hr_data;
  logic [1:0]    hr_resp;
  logic          hr_last;
  logic          hb_valid;
  logic [1:0]    hb_resp;

  modport master (
    output cmd_valid, cmd_write, cmd_bar, cmd_addr, cmd_len,
    output hw_valid, hw_data, hw_strb, hr_ready,
    input  cmd_ready, hw_ready, hr_valid, hr_data, hr_resp, hr_last,
    input  hb_valid, hb_resp
  );
  modport slave (
    input  cmd_valid, cmd_write, cmd_bar, cmd_addr, cmd_len,
    input  hw_valid, hw_data, hw_strb, hr_ready,
    output cmd_ready, hw_ready, hr_valid, hr_data, hr_resp, hr_last,
    output hb_valid, hb_resp
  );
endinterface

// Application side: master = xdma_core, slave = xdma_app model.
interface xdma_core_axi_if #(parameter int DW = 256, parameter int IDW = 4);
  logic [IDW-1:0]  m_axi_awid;
  logic [63:0]     m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic [2:0]      m_axi_awprot;
  logic            m_axi_awlock;
  logic [3:0]      m_axi_awcache;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [IDW-1:0]  m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;
  logic [IDW-1:0]  m_axi_arid;
  logic [63:0]     m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic [2:0]      m_axi_arprot;
  logic            m_axi_arlock;
  logic [3:0]      m_axi_arcache;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [IDW-1:0]  m_axi_rid;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rlast;
  logic            m_axi_rvalid;
  logic            m_axi_rready;
  logic [31:0]     m_axil_awaddr;
  logic [2:0]      m_axil_awprot;
  logic            m_axil_awvalid;
  logic            m_axil_awready;
  logic [31:0]     m_axil_wdata;
  logic [3:0]      m_axil_wstrb;
  logic            m_axil_wvalid;
  logic            m_axil_wready;
  logic [1:0]      m_axil_bresp;
  logic            m_axil_bvalid;
  logic            m_axil_bready;
  logic [31:0]     m_axil_araddr;
  logic [2:0]      m_axil_arprot;
  logic            m_axil_arvalid;
  logic            m_axil_arready;
  logic [31:0]     m_axil_rdata;
  logic [1:0]      m_axil_rresp;
  logic            m_axil_rvalid;
  logic            m_axil_rready;

  modport master (
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_awprot, m_axi_awlock, m_axi_awcache, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arprot, m_axi_arlock, m_axi_arcache, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
    input  m_axil_awready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    input  m_axil_wready,
    input  m_axil_bresp, m_axil_bvalid,
    output m_axil_bready,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    input  m_axil_arready,
    input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    output m_axil_rready
  );
  modport slave (
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_awprot, m_axi_awlock, m_axi_awcache, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arprot, m_axi_arlock, m_axi_arcache, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
    output m_axil_awready,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    output m_axil_wready,
    output m_axil_bresp, m_axil_bvalid,
    input  m_axil_bready,
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
    output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    input  m_axil_rready
  );
endinterface

// File: rtl/xdma_core_irq.sv
// User IRQ front end: rising-edge detect, pending hold, lowest-index-first service.
module xdma_core_irq #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] ack_o,
  output logic         irq_o
);

  logic [N-1:0] req_q, pend_q, ack_q;
  logic [N-1:0] cand, sel, pend_d;
  logic         irq_q;

  // New edges join the pending set immediately so a fresh request is acked next cycle
  always_comb begin
    cand = pend_q | (req_i & ~req_q);
    sel  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
    pend_d = cand & ~sel;
  end

  // Edge history, pending set and the registered one-cycle ack/irq pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= '0;
      pend_q <= '0;
      ack_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      req_q  <= req_i;
      pend_q <= pend_d;
      ack_q  <= sel;
      irq_q  <= |cand;
    end
  end

  assign ack_o = ack_q;
  assign irq_o = irq_q;

endmodule

// File: rtl/xdma_core.sv
// Cycle-level xdma_0 stand-in: host commands become AXI4 bursts (BAR1) or AXI4-Lite singles (BAR0).
module xdma_core
  import xdma_core_pkg::*;
#(
  parameter int C_DATA_WIDTH      = 256,
  parameter int C_M_AXI_ID_WIDTH  = 4,
  parameter int C_NUM_USR_IRQ     = 1,
  parameter int LINK_UP_DELAY     = 16,
  parameter int MSI_VECTORS_LOG2  = 0
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  output logic                     axi_aclk,
  output logic                     axi_aresetn,
  output logic                     user_lnk_up,
  xdma_core_host_if.slave          host,
  xdma_core_axi_if.master          axi,
  input  logic [C_NUM_USR_IRQ-1:0] usr_irq_req,
  output logic [C_NUM_USR_IRQ-1:0] usr_irq_ack,
  output logic                     irq_out,
  output logic                     msi_enable,
  output logic [2:0]               msi_vector_width
);

  localparam int CNT_W = $clog2(LINK_UP_DELAY + 8) + 1;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    aresetn_q, lnk_q;
  logic [63:0]             addr_q;
  logic [7:0]              len_q, beat_q;
  logic                    lw_have_q, lw_aw_q, lw_w_q;
  logic [31:0]             lw_data_q;
  logic [3:0]              lw_strb_q;
  logic                    hb_valid_q;
  logic [1:0]              hb_resp_q;

  assign axi_aclk         = sys_clk;
  assign axi_aresetn      = aresetn_q;
  assign user_lnk_up      = lnk_q;
  assign msi_enable       = 1'b1;
  assign msi_vector_width = 3'(MSI_VECTORS_LOG2);

  // Post-reset timer; saturates so aresetn and link-up only ever rise once
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q     <= '0;
      aresetn_q <= 1'b0;
    end else begin
      if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(3)) aresetn_q <= 1'b1;
    end
  end

  // Transaction FSM; Lite write keeps separate aw/w pending flags so each drops on its own ready
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= LINK_WAIT;
      lnk_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      lw_have_q  <= 1'b0;
      lw_aw_q    <= 1'b0;
      lw_w_q     <= 1'b0;
      lw_data_q  <= '0;
      lw_strb_q  <= '0;
      hb_valid_q <= 1'b0;
      hb_resp_q  <= RESP_OKAY;
    end else begin
      hb_valid_q <= 1'b0;
      case (state_q)
        LINK_WAIT: if (cnt_q == CNT_W'(LINK_UP_DELAY - 1)) begin
          lnk_q   <= 1'b1;
          state_q <= IDLE;
        end
        IDLE: if (host.cmd_valid) begin
          addr_q    <= host.cmd_addr;
          len_q     <= host.cmd_len;
          beat_q    <= '0;
          lw_have_q <= 1'b0;
          case ({host.cmd_bar, host.cmd_write})
            2'b11:   state_q <= MM_AW;
            2'b10:   state_q <= MM_AR;
            2'b01:   state_q <= L_AW_W;
            default: state_q <= L_AR;
          endcase
        end
        MM_AW: if (axi.m_axi_awready) state_q <= MM_W;
        MM_W: if (host.hw_valid && axi.m_axi_wready) begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == len_q) state_q <= MM_B;
        end
        MM_B: if (axi.m_axi_bvalid) begin
          hb_valid_q <= 1'b1;
          hb_resp_q  <= axi.m_axi_bresp;
          state_q    <= IDLE;
        end
        MM_AR: if (axi.m_axi_arready) state_q <= MM_R;
        MM_R: if (axi.m_axi_rvalid && host.hr_ready && axi.m_axi_rlast) state_q <= IDLE;
        L_AW_W: begin
          if (!lw_have_q) begin
            if (host.hw_valid) begin
              lw_data_q <= host.hw_data[31:0];
              lw_strb_q <= host.hw_strb[3:0];
              lw_have_q <= 1'b1;
              lw_aw_q   <= 1'b1;
              lw_w_q    <= 1'b1;
            end
          end else begin
            if (axi.m_axil_awready) lw_aw_q <= 1'b0;
            if (axi.m_axil_wready)  lw_w_q  <= 1'b0;
            if ((!lw_aw_q || axi.m_axil_awready) && (!lw_w_q || axi.m_axil_wready))
              state_q <= L_B;
          end
        end
        L_B: if (axi.m_axil_bvalid) begin
          hb_valid_q <= 1'b1;
          hb_resp_q  <= axi.m_axil_bresp;
          state_q    <= IDLE;
        end
        L_AR: if (axi.m_axil_arready) state_q <= L_R;
        L_R: if (axi.m_axil_rvalid && host.hr_ready) state_q <= IDLE;
        default: state_q <= LINK_WAIT;
      endcase
    end
  end

  // Fixed AXI-MM fields and registered address/length
  assign axi.m_axi_awid    = '0;
  assign axi.m_axi_awaddr  = addr_q;
  assign axi.m_axi_awlen   = len_q;
  assign axi.m_axi_awsize  = axi_size(C_DATA_WIDTH);
  assign axi.m_axi_awburst = BURST_INCR;
  assign axi.m_axi_awprot  = '0;
  assign axi.m_axi_awlock  = 1'b0;
  assign axi.m_axi_awcache = CACHE_DEF;
  assign axi.m_axi_wdata   = host.hw_data;
  assign axi.m_axi_wstrb   = host.hw_strb;
  assign axi.m_axi_arid    = '0;
  assign axi.m_axi_araddr  = addr_q;
  assign axi.m_axi_arlen   = len_q;
  assign axi.m_axi_arsize  = axi_size(C_DATA_WIDTH);
  assign axi.m_axi_arburst = BURST_INCR;
  assign axi.m_axi_arprot  = '0;
  assign axi.m_axi_arlock  = 1'b0;
  assign axi.m_axi_arcache = CACHE_DEF;
  assign axi.m_axil_awaddr  = addr_q[31:0];
  assign axi.m_axil_awprot  = '0;
  assign axi.m_axil_awvalid = lw_aw_q;
  assign axi.m_axil_wdata   = lw_data_q;
  assign axi.m_axil_wstrb   = lw_strb_q;
  assign axi.m_axil_wvalid  = lw_w_q;
  assign axi.m_axil_araddr  = addr_q[31:0];
  assign axi.m_axil_arprot  = '0;
  assign host.hb_valid      = hb_valid_q;
  assign host.hb_resp       = hb_resp_q;

  // Per-state handshake steering; data phases are pure passthrough
  always_comb begin
    host.cmd_ready      = (state_q == IDLE);
    host.hw_ready       = 1'b0;
    host.hr_valid       = 1'b0;
    host.hr_data        = '0;
    host.hr_resp        = RESP_OKAY;
    host.hr_last        = 1'b0;
    axi.m_axi_awvalid   = 1'b0;
    axi.m_axi_wvalid    = 1'b0;
    axi.m_axi_wlast     = 1'b0;
    axi.m_axi_bready    = 1'b0;
    axi.m_axi_arvalid   = 1'b0;
    axi.m_axi_rready    = 1'b0;
    axi.m_axil_bready   = 1'b0;
    axi.m_axil_arvalid  = 1'b0;
    axi.m_axil_rready   = 1'b0;
    case (state_q)
      MM_AW: axi.m_axi_awvalid = 1'b1;
      MM_W: begin
        axi.m_axi_wvalid = host.hw_valid;
        axi.m_axi_wlast  = (beat_q == len_q);
        host.hw_ready    = axi.m_axi_wready;
      end
      MM_B:  axi.m_axi_bready = 1'b1;
      MM_AR: axi.m_axi_arvalid = 1'b1;
      MM_R: begin
        host.hr_valid    = axi.m_axi_rvalid;
        host.hr_data     = axi.m_axi_rdata;
        host.hr_resp     = axi.m_axi_rresp;
        host.hr_last     = axi.m_axi_rlast;
        axi.m_axi_rready = host.hr_ready;
      end
      L_AW_W: host.hw_ready = !lw_have_q;
      L_B:    axi.m_axil_bready = 1'b1;
      L_AR:   axi.m_axil_arvalid = 1'b1;
      L_R: begin
        host.hr_valid     = axi.m_axil_rvalid;
        host.hr_data      = {{(C_DATA_WIDTH-32){1'b0}}, axi.m_axil_rdata};
        host.hr_resp      = axi.m_axil_rresp;
        host.hr_last      = 1'b1;
        axi.m_axil_rready = host.hr_ready;
      end
      default: ;
    endcase
  end

  // IDs are always zero, so returned IDs carry no information
  logic unused_ok;
  assign unused_ok = ^{axi.m_axi_bid, axi.m_axi_rid};

  xdma_core_irq #(.N(C_NUM_USR_IRQ)) u_irq (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .req_i (usr_irq_req),
    .ack_o (usr_irq_ack),
    .irq_o (irq_out)
  );

endmodule

// File: tb/tb_xdma_core.sv
// Directed bench for xdma_core: link-up timing, MM/Lite read/write, IRQ service, mid-burst reset.
module tb_xdma_core;

  localparam int DW  = 256;
  localparam int IDW = 4;
  localparam int NI  = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          axi_aclk, axi_aresetn, user_lnk_up;
  logic [NI-1:0] usr_irq_req, usr_irq_ack;
  logic          irq_out, msi_enable;
  logic [2:0]    msi_vector_width;

  int checks = 0;
  int errors = 0;

  xdma_core_host_if #(.DW(DW))           hif ();
  xdma_core_axi_if  #(.DW(DW), .IDW(IDW)) aif ();

  xdma_core #(
    .C_DATA_WIDTH     (DW),
    .C_M_AXI_ID_WIDTH (IDW),
    .C_NUM_USR_IRQ    (NI),
    .LINK_UP_DELAY    (16),
    .MSI_VECTORS_LOG2 (0)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .axi_aclk         (axi_aclk),
    .axi_aresetn      (axi_aresetn),
    .user_lnk_up      (user_lnk_up),
    .host             (hif),
    .axi              (aif),
    .usr_irq_req      (usr_irq_req),
    .usr_irq_ack      (usr_irq_ack),
    .irq_out          (irq_out),
    .msi_enable       (msi_enable),
    .msi_vector_width (msi_vector_width)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Present one command in IDLE and complete its handshake
  task automatic send_cmd(input logic wr, input logic bar, input logic [63:0] addr,
                          input logic [7:0] len);
    hif.cmd_write = wr;
    hif.cmd_bar   = bar;
    hif.cmd_addr  = addr;
    hif.cmd_len   = len;
    hif.cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", 256'(hif.cmd_ready), 256'(1));
    tick();
    hif.cmd_valid = 1'b0;
    #1;
  endtask

  initial begin
    hif.cmd_valid = 0; hif.cmd_write = 0; hif.cmd_bar = 0; hif.cmd_addr = '0; hif.cmd_len = '0;
    hif.hw_valid = 0; hif.hw_data = '0; hif.hw_strb = '0; hif.hr_ready = 0;
    aif.m_axi_awready = 0; aif.m_axi_wready = 0; aif.m_axi_bid = '0; aif.m_axi_bresp = 0;
    aif.m_axi_bvalid = 0; aif.m_axi_arready = 0; aif.m_axi_rid = '0; aif.m_axi_rdata = '0;
    aif.m_axi_rresp = 0; aif.m_axi_rlast = 0; aif.m_axi_rvalid = 0;
    aif.m_axil_awready = 0; aif.m_axil_wready = 0; aif.m_axil_bresp = 0; aif.m_axil_bvalid = 0;
    aif.m_axil_arready = 0; aif.m_axil_rdata = '0; aif.m_axil_rresp = 0; aif.m_axil_rvalid = 0;
    usr_irq_req = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_lnk",      256'(user_lnk_up), 256'(0));
    chk("rst_aresetn",  256'(axi_aresetn), 256'(0));
    chk("rst_cmd_rdy",  256'(hif.cmd_ready), 256'(0));
    chk("rst_awvalid",  256'(aif.m_axi_awvalid), 256'(0));
    chk("rst_wvalid",   256'(aif.m_axi_wvalid), 256'(0));
    chk("rst_arvalid",  256'(aif.m_axi_arvalid), 256'(0));
    chk("rst_lawvalid", 256'(aif.m_axil_awvalid), 256'(0));
    chk("rst_irq",      256'(irq_out), 256'(0));
    chk("rst_ack",      256'(usr_irq_ack), 256'(0));
    chk("msi_en",       256'(msi_enable), 256'(1));
    chk("msi_vw",       256'(msi_vector_width), 256'(0));

    // Reset release: aresetn after 4 edges, link-up after 16
    sys_rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 3)  chk("aresetn_c3",  256'(axi_aresetn), 256'(0));
      if (n == 4)  chk("aresetn_c4",  256'(axi_aresetn), 256'(1));
      if (n == 15) chk("lnk_c15",     256'(user_lnk_up), 256'(0));
      if (n == 15) chk("cmd_rdy_c15", 256'(hif.cmd_ready), 256'(0));
      if (n == 16) chk("lnk_c16",     256'(user_lnk_up), 256'(1));
    end

    // MM write 0x1000, 4 beats, awready delayed 2 cycles
    send_cmd(1'b1, 1'b1, 64'h1000, 8'd3);
    chk("mmw_awvalid", 256'(aif.m_axi_awvalid), 256'(1));
    chk("mmw_awaddr",  256'(aif.m_axi_awaddr), 256'h1000);
    chk("mmw_awlen",   256'(aif.m_axi_awlen), 256'(3));
    chk("mmw_awsize",  256'(aif.m_axi_awsize), 256'(5));
    chk("mmw_awburst", 256'(aif.m_axi_awburst), 256'(1));
    chk("mmw_awcache", 256'(aif.m_axi_awcache), 256'(3));
    chk("mmw_cmd_rdy", 256'(hif.cmd_ready), 256'(0));
    tick();
    chk("mmw_awhold",  256'(aif.m_axi_awvalid), 256'(1));
    aif.m_axi_awready = 1'b1;
    tick();
    aif.m_axi_awready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hif.hw_valid = 1'b1;
      hif.hw_data  = 256'(160 + i);
      hif.hw_strb  = '1;
      if (i == 1) begin
        aif.m_axi_wready = 1'b0;
        #1;
        chk("mmw_stall_hwrdy", 256'(hif.hw_ready), 256'(0));
        chk("mmw_stall_wlast", 256'(aif.m_axi_wlast), 256'(0));
        tick();
      end
      aif.m_axi_wready = 1'b1;
      #1;
      chk("mmw_wvalid", 256'(aif.m_axi_wvalid), 256'(1));
      chk("mmw_wdata",  aif.m_axi_wdata, 256'(160 + i));
      chk("mmw_wlast",  256'(aif.m_axi_wlast), 256'(i == 3));
      tick();
    end
    hif.hw_valid = 1'b0;
    aif.m_axi_wready = 1'b0;
    #1;
    chk("mmw_bready", 256'(aif.m_axi_bready), 256'(1));
    chk("mmw_hb_pre", 256'(hif.hb_valid), 256'(0));
    aif.m_axi_bvalid = 1'b1;
    aif.m_axi_bresp  = 2'b00;
    tick();
    aif.m_axi_bvalid = 1'b0;
    #1;
    chk("mmw_hb_valid", 256'(hif.hb_valid), 256'(1));
    chk("mmw_hb_resp",  256'(hif.hb_resp), 256'(0));
    tick();
    chk("mmw_hb_pulse", 256'(hif.hb_valid), 256'(0));

    // MM read 0x2000, 2 beats, hr_ready toggling
    send_cmd(1'b0, 1'b1, 64'h2000, 8'd1);
    chk("mmr_arvalid", 256'(aif.m_axi_arvalid), 256'(1));
    chk("mmr_araddr",  256'(aif.m_axi_araddr), 256'h2000);
    chk("mmr_arlen",   256'(aif.m_axi_arlen), 256'(1));
    aif.m_axi_arready = 1'b1;
    tick();
    aif.m_axi_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      aif.m_axi_rvalid = 1'b1;
      aif.m_axi_rdata  = 256'(32'h111 * (b + 1));
      aif.m_axi_rlast  = (b == 1);
      hif.hr_ready     = 1'b0;
      #1;
      chk("mmr_rready_lo", 256'(aif.m_axi_rready), 256'(0));
      chk("mmr_hr_valid",  256'(hif.hr_valid), 256'(1));
      tick();
      hif.hr_ready = 1'b1;
      #1;
      chk("mmr_rready_hi", 256'(aif.m_axi_rready), 256'(1));
      chk("mmr_hr_data",   hif.hr_data, 256'(32'h111 * (b + 1)));
      chk("mmr_hr_last",   256'(hif.hr_last), 256'(b == 1));
      tick();
    end
    aif.m_axi_rvalid = 1'b0;
    aif.m_axi_rlast  = 1'b0;
    hif.hr_ready     = 1'b0;
    #1;
    chk("mmr_back_idle", 256'(hif.cmd_ready), 256'(1));

    // Lite write 0x10 <- DEADBEEF, wready 3 cycles after awready
    send_cmd(1'b1, 1'b0, 64'h10, 8'd5);
    chk("lw_hw_ready", 256'(hif.hw_ready), 256'(1));
    chk("lw_aw_early", 256'(aif.m_axil_awvalid), 256'(0));
    hif.hw_valid = 1'b1;
    hif.hw_data  = 256'h5555_0000_DEADBEEF;
    hif.hw_strb  = '1;
    tick();
    hif.hw_valid = 1'b0;
    #1;
    chk("lw_awvalid", 256'(aif.m_axil_awvalid), 256'(1));
    chk("lw_wvalid",  256'(aif.m_axil_wvalid), 256'(1));
    chk("lw_awaddr",  256'(aif.m_axil_awaddr), 256'h10);
    chk("lw_wdata",   256'(aif.m_axil_wdata), 256'hDEADBEEF);
    chk("lw_wstrb",   256'(aif.m_axil_wstrb), 256'hF);
    aif.m_axil_awready = 1'b1;
    tick();
    aif.m_axil_awready = 1'b0;
    #1;
    chk("lw_aw_drop", 256'(aif.m_axil_awvalid), 256'(0));
    chk("lw_w_hold",  256'(aif.m_axil_wvalid), 256'(1));
    repeat (2) tick();
    chk("lw_w_hold3", 256'(aif.m_axil_wvalid), 256'(1));
    aif.m_axil_wready = 1'b1;
    tick();
    aif.m_axil_wready = 1'b0;
    #1;
    chk("lw_w_drop", 256'(aif.m_axil_wvalid), 256'(0));
    chk("lw_bready", 256'(aif.m_axil_bready), 256'(1));
    aif.m_axil_bvalid = 1'b1;
    aif.m_axil_bresp  = 2'b10;
    tick();
    aif.m_axil_bvalid = 1'b0;
    #1;
    chk("lw_hb_valid", 256'(hif.hb_valid), 256'(1));
    chk("lw_hb_resp",  256'(hif.hb_resp), 256'(2));

    // Lite read 0x14 -> 12345678, SLVERR
    tick();
    send_cmd(1'b0, 1'b0, 64'h14, 8'd0);
    chk("lr_arvalid", 256'(aif.m_axil_arvalid), 256'(1));
    chk("lr_araddr",  256'(aif.m_axil_araddr), 256'h14);
    aif.m_axil_arready = 1'b1;
    tick();
    aif.m_axil_arready = 1'b0;
    aif.m_axil_rvalid  = 1'b1;
    aif.m_axil_rdata   = 32'h12345678;
    aif.m_axil_rresp   = 2'b10;
    hif.hr_ready       = 1'b1;
    #1;
    chk("lr_hr_valid", 256'(hif.hr_valid), 256'(1));
    chk("lr_hr_data",  hif.hr_data, 256'h12345678);
    chk("lr_hr_resp",  256'(hif.hr_resp), 256'(2));
    chk("lr_hr_last",  256'(hif.hr_last), 256'(1));
    chk("lr_rready",   256'(aif.m_axil_rready), 256'(1));
    tick();
    aif.m_axil_rvalid = 1'b0;
    hif.hr_ready      = 1'b0;

    // IRQ: both lines rise together, bit 0 served first
    usr_irq_req = 2'b11;
    tick();
    chk("irq_ack0", 256'(usr_irq_ack), 256'(1));
    chk("irq_out0", 256'(irq_out), 256'(1));
    tick();
    chk("irq_ack1", 256'(usr_irq_ack), 256'(2));
    chk("irq_out1", 256'(irq_out), 256'(1));
    tick();
    chk("irq_ack_done", 256'(usr_irq_ack), 256'(0));
    chk("irq_out_done", 256'(irq_out), 256'(0));
    usr_irq_req = 2'b01;
    tick();
    chk("irq_fall_none", 256'(irq_out), 256'(0));
    usr_irq_req = 2'b11;
    tick();
    chk("irq_single1", 256'(usr_irq_ack), 256'(2));

    // Reset during MM_W aborts immediately
    send_cmd(1'b1, 1'b1, 64'h3000, 8'd7);
    aif.m_axi_awready = 1'b1;
    tick();
    aif.m_axi_awready = 1'b0;
    hif.hw_valid = 1'b1;
    aif.m_axi_wready = 1'b1;
    tick();
    #1;
    chk("mid_wvalid_pre", 256'(aif.m_axi_wvalid), 256'(1));
    sys_rst = 1'b1;
    tick();
    chk("mid_rst_wvalid",  256'(aif.m_axi_wvalid), 256'(0));
    chk("mid_rst_awvalid", 256'(aif.m_axi_awvalid), 256'(0));
    chk("mid_rst_bready",  256'(aif.m_axi_bready), 256'(0));
    chk("mid_rst_hwrdy",   256'(hif.hw_ready), 256'(0));
    chk("mid_rst_lnk",     256'(user_lnk_up), 256'(0));
    chk("mid_rst_aresetn", 256'(axi_aresetn), 256'(0));
    chk("mid_rst_ack",     256'(usr_irq_ack), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
